pixel_frame_writer: RTL

Consumer-side block for the per-pixel processing stream. It accepts processed 8-bit pixels over a valid/ready handshake, counts columns and rows against a fixed image size, packs four pixels per 32-bit word and issues word writes to frame memory starting at a programmable base address. It sits between the pixel operator's output byte stream and the frame buffer, and signals completion once the last word of a frame has been accepted by memory.

---
 rtl/pfw_pkg.sv | 21 ++
 rtl/pfw_word_fifo.sv | 60 ++++++
 rtl/pixel_frame_writer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pfw_pkg.sv
// ============================================================================
// pfw_pkg: shared types and constants for pixel_frame_writer.      Rev 1.0
// ============================================================================
`default_nettype none

package pfw_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } pfw_state_e;

  localparam int PIX_PER_WORD = 4;
  localparam int LANE_W       = 8;
  localparam int WORD_W       = PIX_PER_WORD * LANE_W;

endpackage

`default_nettype wire

// File: rtl/pfw_word_fifo.sv
// ============================================================================
// pfw_word_fifo: first-word-fall-through synchronous word FIFO.     Rev 1.0
// ============================================================================
`default_nettype none

module pfw_word_fifo
  import pfw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the read side is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/pixel_frame_writer.sv
// ============================================================================
// pixel_frame_writer: packs 8-bit pixels into 32-bit frame-memory word writes.
// Optional feature macro PIXEL_FRAME_WRITER_CHECKSUM_EN adds frame_sum. Rev 1.0
// ============================================================================
`default_nettype none

module pixel_frame_writer
  import pfw_pkg::*;
#(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     pix_valid,
  input  logic [LANE_W-1:0]        pix_data,
  output logic                     pix_ready,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WORD_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]              frame_sum
`endif
);

  localparam int COL_W       = $clog2(IMG_W);
  localparam int ROW_W       = $clog2(IMG_H);
  localparam int LANE_CW     = $clog2(PIX_PER_WORD);
  localparam int PACK_W      = (PIX_PER_WORD - 1) * LANE_W;
  localparam int TOTAL_WORDS = IMG_W * IMG_H / PIX_PER_WORD;

  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [LANE_CW-1:0] LANE_LAST = LANE_CW'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0]  WORD_LAST = ADDR_W'(TOTAL_WORDS - 1);

  pfw_state_e         state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [LANE_CW-1:0] lane_q, lane_d;
  logic [PACK_W-1:0]  pack_q, pack_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               fifo_full, fifo_empty, fifo_push;
  logic [WORD_W-1:0]  fifo_dout;
  logic               pix_acc, wr_acc, last_pix, last_word, arm;

  assign pix_ready  = (state_q == S_ACCEPT) && !fifo_full;
  assign pix_acc    = pix_valid && pix_ready;
  assign wr_valid   = !fifo_empty;
  assign wr_acc     = wr_valid && wr_ready;
  assign wr_data    = fifo_empty ? '0 : fifo_dout;
  assign wr_addr    = wr_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign col        = col_q;
  assign row        = row_q;

  assign arm       = (state_q == S_IDLE) && start;
  assign last_pix  = pix_acc && (col_q == COL_LAST) && (row_q == ROW_LAST);
  // The final handshake itself moves DRAIN to DONE, so frame_done follows it by one cycle.
  assign last_word = wr_acc && (wr_cnt_q == WORD_LAST);
  assign fifo_push = pix_acc && (lane_q == LANE_LAST);

  pfw_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (wr_acc),
    .din   ({pix_data, pack_q}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    wr_addr_d = wr_addr_q;
    wr_cnt_d  = wr_cnt_q;

    unique case (state_q)
      S_IDLE:   if (start)     state_d = S_ACCEPT;
      S_ACCEPT: if (last_pix)  state_d = S_DRAIN;
      S_DRAIN:  if (last_word) state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase

    if (arm) begin
      col_d     = '0;
      row_d     = '0;
      lane_d    = '0;
      wr_addr_d = base_addr;
      wr_cnt_d  = '0;
    end

    if (pix_acc) begin
      lane_d = lane_q + 1'b1;
      // Earliest pixel shifts down toward bits [7:0] as later ones arrive.
      pack_d = {pix_data, pack_q[PACK_W-1:LANE_W]};
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (wr_acc) begin
      wr_addr_d = wr_addr_q + 1'b1;
      wr_cnt_d  = wr_cnt_q + 1'b1;
    end

    busy_d       = (state_d == S_ACCEPT) || (state_d == S_DRAIN);
    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      wr_addr_q    <= '0;
      wr_cnt_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      wr_addr_q    <= wr_addr_d;
      wr_cnt_q     <= wr_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (arm)          sum_d = '0;
    else if (pix_acc) sum_d = sum_q + 16'(pix_data);
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign frame_sum = sum_q;
`endif

endmodule

`default_nettype wire
